// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, funct3 addressing modes and byte-lane helpers for the data cache.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} dcache_state_t;
  localparam logic [2:0] AM_B  = 3'b000;
  localparam logic [2:0] AM_H  = 3'b001;
  localparam logic [2:0] AM_W  = 3'b010;
  localparam logic [2:0] AM_BU = 3'b100;
  localparam logic [2:0] AM_HU = 3'b101;
  // funct3[1:0] alone selects the access size; the unsigned bit only matters on loads
  function automatic logic [3:0] store_strobe(input logic [2:0] mode, input logic [1:0] off);
    return mode[1:0] == 2'b00 ? 4'b0001 << off : mode[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  endfunction
  function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] mode,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    return mode == AM_B  ? {{24{sh[7]}}, sh[7:0]} :
           mode == AM_H  ? {{16{sh[15]}}, sh[15:0]} :
           mode == AM_BU ? {24'b0, sh[7:0]} :
           mode == AM_HU ? {16'b0, sh[15:0]} : word;
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped valid/tag/data storage, combinational read, byte-enabled write.
module dcache_array #(
  parameter int NUM_LINES = 64,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx_i,
  output logic               valid_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [31:0]        data_o,
  input  logic               we_i,
  input  logic               fill_i,
  input  logic [3:0]         be_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic [31:0]        data_i
);
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (we_i && fill_i) valid_q[idx_i] <= 1'b1;
  end
  // tags and data need no reset: nothing reads them until the valid bit is set
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (fill_i) tag_q[idx_i] <= tag_i;
      for (int b = 0; b < 4; b++) if (be_i[b]) data_q[idx_i][8*b +: 8] <= data_i[8*b +: 8];
    end
  end
  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: MEM-stage write-through, no-write-allocate data cache controller.
// Sequences refills and write-throughs; the stalled pipeline holds the request inputs steady.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      aluResultM,
  input  logic [31:0]      writeDataM,
  input  logic             memReadM,
  input  logic             memWriteM,
  input  logic [2:0]       addressingmodeM,
  output logic [31:0]      readDataM,
  output logic             stallMem,
  output logic             flushW,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hitCount,
  output logic [CNT_W-1:0] missCount
);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 30 - INDEX_W;
  dcache_state_t state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic whit_q, whit_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic line_valid, hit, stall, req, we, arr_we, fill;
  logic [TAG_W-1:0] line_tag;
  logic [31:0] line_data, arr_data;
  logic [3:0] strb, be;
  wire [1:0] off = aluResultM[1:0];
  wire [TAG_W-1:0] tag = aluResultM[31:INDEX_W+2];
  dcache_array #(.NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk(clk), .rst(rst), .idx_i(aluResultM[INDEX_W+1:2]),
    .valid_o(line_valid), .tag_o(line_tag), .data_o(line_data),
    .we_i(arr_we), .fill_i(fill), .be_i(be), .tag_i(tag), .data_i(arr_data)
  );
  assign hit  = line_valid && line_tag == tag;
  assign strb = store_strobe(addressingmodeM, off);
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    whit_d    = whit_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    stall     = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    arr_we    = 1'b0;
    fill      = 1'b0;
    be        = 4'b1111;
    arr_data  = mem_rdata;
    readDataM = '0;
    case (state_q)
      IDLE: begin
        if (memWriteM) begin
          stall   = 1'b1;
          whit_d  = hit;
          state_d = WRITE;
        end else if (memReadM && hit) begin
          readDataM = load_extend(line_data, addressingmodeM, off);
          hit_d     = hit_q + CNT_W'(1);
        end else if (memReadM) begin
          stall   = 1'b1;
          miss_d  = miss_q + CNT_W'(1);
          state_d = REFILL;
        end
      end
      REFILL: begin
        req   = 1'b1;
        stall = 1'b1;
        if (mem_ready) begin
          arr_we  = 1'b1;
          fill    = 1'b1;
          buf_d   = mem_rdata;
          state_d = DONE;
        end
      end
      WRITE: begin
        req   = 1'b1;
        we    = 1'b1;
        stall = 1'b1;
        if (mem_ready) begin
          arr_we   = whit_q;
          be       = strb;
          arr_data = mem_wdata;
          state_d  = DONE;
        end
      end
      DONE: begin
        readDataM = memReadM && !memWriteM ? load_extend(buf_q, addressingmodeM, off) : '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      whit_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      whit_q  <= whit_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end
  // a live access during reset must not leak a stall or request
  assign stallMem  = stall & ~rst;
  assign flushW    = stallMem;
  assign mem_req   = req & ~rst;
  assign mem_we    = we & ~rst;
  assign mem_wstrb = state_q == WRITE && !rst ? strb : 4'b0000;
  assign mem_addr  = {aluResultM[31:2], 2'b00};
  assign mem_wdata = store_align(writeDataM, off);
  assign hitCount  = hit_q;
  assign missCount = miss_q;
endmodule
